button_conditioner: RTL

//  Conditions one raw push-button (the calculator "next" key) before it reaches the control FSM:
//  2-FF synchroniser, counter-based debounce, single-cycle press/release strobes, long-press flag.

---
 rtl/button_conditioner.sv | 112 +++++++++++
 1 files changed

// File: rtl/button_conditioner.sv
// Push-button front end: 2-FF synchroniser, counter debounce, press/release strobes, long-press flag.
// Output btn_press is meant to replace raw edge detection in the downstream control FSM.
//
// state        | meaning
// RELEASED     | stable released, waiting for synced press
// PRESS_PEND   | synced press seen, counting debounce window
// PRESSED      | accepted press, timing long-press
// RELEASE_PEND | synced release seen, counting debounce window
module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned LONG_CYCLES     = 50_000_000,
  parameter bit          ACTIVE_LOW      = 1'b1,
  parameter int unsigned CNT_W           = 26
) (
  input  logic       CLK,
  input  logic       clear,
  input  logic       btn_raw,
  output logic       btn_level,
  output logic       btn_press,
  output logic       btn_release,
  output logic       btn_long,
  output logic [1:0] state_out
);

  localparam logic [1:0] RELEASED     = 2'b00;
  localparam logic [1:0] PRESS_PEND   = 2'b01;
  localparam logic [1:0] PRESSED      = 2'b10;
  localparam logic [1:0] RELEASE_PEND = 2'b11;

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic             pressed_raw;
  logic             s1;
  logic             s2;
  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;

  // Normalise polarity before synchronising so the FSM always sees 1 = pressed.
  assign pressed_raw = btn_raw ^ ACTIVE_LOW;
  assign state_out   = state;

  always_ff @(posedge CLK) begin
    if (clear) begin
      s1          <= 1'b0;
      s2          <= 1'b0;
      state       <= RELEASED;
      cnt         <= '0;
      btn_level   <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
      btn_long    <= 1'b0;
    end else begin
      s1          <= pressed_raw;
      s2          <= s1;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
      case (state)
        RELEASED: begin
          if (s2) begin
            state <= PRESS_PEND;
            cnt   <= '0;
          end
        end
        PRESS_PEND: begin
          if (!s2) begin
            state <= RELEASED;
            cnt   <= '0;
          end else if (cnt == DEB_LAST) begin
            state     <= PRESSED;
            cnt       <= '0;
            btn_press <= 1'b1;
            btn_level <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        PRESSED: begin
          // Counter parks at LONG_LAST so it never wraps during a very long hold.
          if (!s2) begin
            state <= RELEASE_PEND;
            cnt   <= '0;
          end else if (cnt == LONG_LAST) begin
            btn_long <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        RELEASE_PEND: begin
          if (s2) begin
            state <= PRESSED;
            cnt   <= '0;
          end else if (cnt == DEB_LAST) begin
            state       <= RELEASED;
            cnt         <= '0;
            btn_release <= 1'b1;
            btn_level   <= 1'b0;
            btn_long    <= 1'b0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state <= RELEASED;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
